// File: rtl/ldpc_shuffle_pkg.sv
// Shared constants and types for the LDPC shuffle scheduler: per-fold shift split factors and FSM state type.
package ldpc_shuffle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VN_ISSUE,
    ST_VN_DRAIN,
    ST_CN_ISSUE,
    ST_CN_DRAIN
  } sched_state_t;

  function automatic int shift_factor0(input int fold);
    case (fold)
      1:       return 90;
      2:       return 45;
      3:       return 30;
      default: return 23;
    endcase
  endfunction

  function automatic int shift_factor1(input int fold);
    case (fold)
      1:       return 12;
      2:       return 6;
      3:       return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int last_shift_dist(input int fold);
    case (fold)
      1:       return 11;
      2:       return 5;
      3:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int last_shift_width(input int fold);
    case (fold)
      1:       return 4;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int log2_instances(input int fold);
    case (fold)
      1:       return 9;
      2:       return 8;
      default: return 7;
    endcase
  endfunction

endpackage

// File: rtl/ldpc_shift_split.sv
// Splits a fetched shift into coarse/medium/fine pieces staggered one cycle apart to line up with
// the three shuffle pipeline stages, and carries the matching valid pipe.
module ldpc_shift_split
  import ldpc_shuffle_pkg::*;
#(
  parameter int FOLDFACTOR     = 4,
  parameter int NUMINSTANCES   = 90,
  parameter int LOG2INSTANCES  = 7,
  parameter int LASTSHIFTWIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd,
  input  logic                      err_clr,
  input  logic [LOG2INSTANCES-1:0]  rom_shift,
  output logic [1:0]                shift0,
  output logic [2:0]                shift1,
  output logic [LASTSHIFTWIDTH-1:0] shift2,
  output logic                      valid_in,
  output logic                      valid_out,
  output logic                      err_range,
  output logic                      front_busy
);

  localparam int SF0 = shift_factor0(FOLDFACTOR);
  localparam int SF1 = shift_factor1(FOLDFACTOR);

  logic                     v0, v1, v2, v3;
  logic                     range_bad;
  logic [LOG2INSTANCES-1:0] s;
  logic [LOG2INSTANCES-1:0] rem0, rem0_q;
  logic [1:0]               shift0_now, shift0_q;
  logic [2:0]               shift1_now;

  always_comb begin
    range_bad  = (int'(rom_shift) >= NUMINSTANCES);
    s          = range_bad ? '0 : rom_shift;
    shift0_now = 2'(int'(s) / SF0);
    rem0       = LOG2INSTANCES'(int'(s) % SF0);
    shift1_now = 3'(int'(rem0) / SF1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      shift0_q  <= '0;
      shift1    <= '0;
      shift2    <= '0;
      rem0_q    <= '0;
      err_range <= 1'b0;
    end else begin
      v0 <= rd;
      v1 <= v0;
      v2 <= v1;
      v3 <= v2;
      if (v0) begin
        shift0_q <= shift0_now;
        shift1   <= shift1_now;
        rem0_q   <= rem0;
      end
      if (v1) shift2 <= LASTSHIFTWIDTH'(int'(rem0_q) % SF1);
      if (err_clr)             err_range <= 1'b0;
      else if (v0 && range_bad) err_range <= 1'b1;
    end
  end

  // ROM data arrives combinationally in the first stage; hold the last value on bubbles
  assign shift0     = v0 ? shift0_now : shift0_q;
  assign valid_in   = v0;
  assign valid_out  = v3;
  assign front_busy = v0 | v1 | v2;

endmodule

// File: rtl/ldpc_shuffle_sched.sv
// Row sequencer for one ldpc_shuffle instance: VN pass then CN pass over the same ROM shift entries.
//  state        | meaning
//  ST_IDLE      | waiting for start
//  ST_VN_ISSUE  | issuing ROM reads for VN phase (first_half=1)
//  ST_VN_DRAIN  | VN reads done, waiting for split pipe to empty
//  ST_CN_ISSUE  | issuing ROM reads for CN phase (first_half=0)
//  ST_CN_DRAIN  | CN reads done, waiting for last sh_valid_out, then done
module ldpc_shuffle_sched
  import ldpc_shuffle_pkg::*;
#(
  parameter int FOLDFACTOR     = 4,
  parameter int NUMINSTANCES   = 90,
  parameter int LOG2INSTANCES  = 7,
  parameter int LASTSHIFTWIDTH = 2,
  parameter int ADDRWIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDRWIDTH-1:0]      base_addr,
  input  logic [ADDRWIDTH-1:0]      num_edges,
  input  logic                      hold,
  output logic                      busy,
  output logic                      done,
  output logic                      rom_rd,
  output logic [ADDRWIDTH-1:0]      rom_addr,
  input  logic [LOG2INSTANCES-1:0]  rom_shift,
  output logic                      first_half,
  output logic [1:0]                shift0,
  output logic [2:0]                shift1,
  output logic [LASTSHIFTWIDTH-1:0] shift2,
  output logic                      sh_valid_in,
  output logic                      sh_valid_out,
  output logic                      err_range
);

  sched_state_t         state;
  logic [ADDRWIDTH-1:0] base_q, num_q, rd_addr, left;
  logic                 issuing, err_clr, front_busy;

  assign issuing  = (state == ST_VN_ISSUE) || (state == ST_CN_ISSUE);
  assign rom_rd   = issuing && !hold;
  assign rom_addr = rd_addr;
  assign err_clr  = start && (state == ST_IDLE);

  // left counts down remaining reads; the drain states rely on the split pipe's occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      rd_addr    <= '0;
      left       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      first_half <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            num_q   <= num_edges;
            rd_addr <= base_addr;
            left    <= num_edges;
            if (num_edges == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_VN_ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        ST_VN_ISSUE, ST_CN_ISSUE: begin
          if (!hold) begin
            rd_addr <= rd_addr + ADDRWIDTH'(1);
            left    <= left - ADDRWIDTH'(1);
            if (left == ADDRWIDTH'(1))
              state <= (state == ST_VN_ISSUE) ? ST_VN_DRAIN : ST_CN_DRAIN;
          end
        end
        ST_VN_DRAIN: begin
          if (!front_busy) begin
            state      <= ST_CN_ISSUE;
            first_half <= 1'b0;
            rd_addr    <= base_q;
            left       <= num_q;
          end
        end
        ST_CN_DRAIN: begin
          if (!front_busy) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            first_half <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ldpc_shift_split #(
    .FOLDFACTOR    (FOLDFACTOR),
    .NUMINSTANCES  (NUMINSTANCES),
    .LOG2INSTANCES (LOG2INSTANCES),
    .LASTSHIFTWIDTH(LASTSHIFTWIDTH)
  ) u_split (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd        (rom_rd),
    .err_clr   (err_clr),
    .rom_shift (rom_shift),
    .shift0    (shift0),
    .shift1    (shift1),
    .shift2    (shift2),
    .valid_in  (sh_valid_in),
    .valid_out (sh_valid_out),
    .err_range (err_range),
    .front_busy(front_busy)
  );

endmodule

// File: tb/tb_ldpc_shuffle_sched.sv
// Directed bench for ldpc_shuffle_sched: ROM model, event logger, and row-level checks of timing and split values.
module tb_ldpc_shuffle_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr, num_edges;
  logic       hold;
  logic       busy, done, rom_rd;
  logic [7:0] rom_addr;
  logic [6:0] rom_shift;
  logic       first_half;
  logic [1:0] shift0;
  logic [2:0] shift1;
  logic [1:0] shift2;
  logic       sh_valid_in, sh_valid_out, err_range;

  logic [6:0] rom_mem [256];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  int rd_a [512], rd_fh [512], rd_c [512];
  int vin_c [512], vout_c [512];
  int cap0 [512], cap1 [512], cap2 [512];
  int nr = 0, nv = 0, nvo = 0, ndone = 0, done_c = 0, busy_at_done = 0;
  int p1 = -1, p2 = -1;

  ldpc_shuffle_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_edges   (num_edges),
    .hold        (hold),
    .busy        (busy),
    .done        (done),
    .rom_rd      (rom_rd),
    .rom_addr    (rom_addr),
    .rom_shift   (rom_shift),
    .first_half  (first_half),
    .shift0      (shift0),
    .shift1      (shift1),
    .shift2      (shift2),
    .sh_valid_in (sh_valid_in),
    .sh_valid_out(sh_valid_out),
    .err_range   (err_range)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rom_rd) rom_shift <= rom_mem[rom_addr];

  // event log, sampled mid-cycle; indices of read k, sh_valid_in k and sh_valid_out k line up
  always @(negedge clk) begin
    if (!rst_n) begin
      nv  = nr;
      nvo = nr;
      p1  = -1;
      p2  = -1;
    end else begin
      if (p2 >= 0 && p2 < 512) cap2[p2] = int'(shift2);
      if (p1 >= 0 && p1 < 512) cap1[p1] = int'(shift1);
      p2 = p1;
      p1 = -1;
      if (sh_valid_in && nv < 512) begin
        cap0[nv]  = int'(shift0);
        vin_c[nv] = cyc;
        p1 = nv;
        nv++;
      end
      if (sh_valid_out && nvo < 512) begin
        vout_c[nvo] = cyc;
        nvo++;
      end
      if (rom_rd && nr < 512) begin
        rd_a[nr]  = int'(rom_addr);
        rd_fh[nr] = int'(first_half);
        rd_c[nr]  = cyc;
        nr++;
      end
      if (done) begin
        done_c       = cyc;
        busy_at_done = int'(busy);
        ndone++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_row(input int b, input int n);
    @(posedge clk); #1;
    base_addr = 8'(b);
    num_edges = 8'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int t = 0;
    while (ndone == d0 && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_done_seen"}, ndone > d0, 1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_row(input string tag, input int k0, input int base, input int n, input int d0);
    int a, v, s, last;
    chk({tag, "_nrd"}, nr - k0, 2 * n);
    chk({tag, "_nvin"}, nv - k0, 2 * n);
    chk({tag, "_nvout"}, nvo - k0, 2 * n);
    chk({tag, "_ndone"}, ndone - d0, 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
    last = k0 + 2 * n - 1;
    chk({tag, "_done_after_last_vout"}, done_c, vout_c[last] + 1);
    chk({tag, "_phase_gap"}, (rd_c[k0 + n] - rd_c[k0 + n - 1]) >= 4, 1);
    for (int j = 0; j < 2 * n; j++) begin
      a = (base + (j % n)) % 256;
      v = int'(rom_mem[a]);
      s = (v >= 90) ? 0 : v;
      chk({tag, "_addr"}, rd_a[k0 + j], a);
      chk({tag, "_first_half"}, rd_fh[k0 + j], (j < n) ? 1 : 0);
      chk({tag, "_vin_lat"}, vin_c[k0 + j], rd_c[k0 + j] + 1);
      chk({tag, "_vout_lat"}, vout_c[k0 + j], vin_c[k0 + j] + 3);
      chk({tag, "_rotate"}, cap0[k0 + j] * 23 + cap1[k0 + j] * 3 + cap2[k0 + j], s);
    end
    chk({tag, "_idle_first_half"}, first_half, 1);
  endtask

  initial begin
    int k0, d0, t;
    int sp_in [4]  = '{89, 22, 23, 0};
    int sp_e0 [4]  = '{3, 0, 1, 0};
    int sp_e1 [4]  = '{6, 7, 0, 0};
    int sp_e2 [4]  = '{2, 1, 0, 0};

    for (int i = 0; i < 256; i++) rom_mem[i] = 7'((i * 37) % 90);
    for (int i = 0; i < 4; i++) rom_mem[i] = 7'(sp_in[i]);
    rom_mem[10] = 7'd5;  rom_mem[11] = 7'd89; rom_mem[12] = 7'd0;
    rom_mem[20] = 7'd95;

    rst_n = 1'b1; start = 1'b0; base_addr = '0; num_edges = '0; hold = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_rd", rom_rd, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_first_half", first_half, 1);
    chk("rst_shifts", {shift0, shift1, shift2}, 0);
    chk("rst_valids", {sh_valid_in, sh_valid_out}, 0);
    chk("rst_err", err_range, 0);
    rst_n = 1'b1;

    // split table: 89,22,23,0 in both phases
    k0 = nr; d0 = ndone;
    start_row(0, 4);
    wait_done("split", d0, 200);
    check_row("split", k0, 0, 4, d0);
    for (int j = 0; j < 8; j++) begin
      chk("split_shift0", cap0[k0 + j], sp_e0[j % 4]);
      chk("split_shift1", cap1[k0 + j], sp_e1[j % 4]);
      chk("split_shift2", cap2[k0 + j], sp_e2[j % 4]);
    end
    chk("split_err", err_range, 0);

    // basic row, with a start pulse while busy that must be ignored
    k0 = nr; d0 = ndone;
    start_row(10, 3);
    @(posedge clk); #1;
    base_addr = 8'd100; num_edges = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("row", d0, 200);
    check_row("row", k0, 10, 3, d0);

    // two hold bubbles mid-issue, address wrap 254..1
    rom_mem[254] = 7'd44; rom_mem[255] = 7'd67; rom_mem[0] = 7'd89; rom_mem[1] = 7'd13;
    k0 = nr; d0 = ndone;
    start_row(254, 4);
    t = 0;
    while (nr - k0 < 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    hold = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    hold = 1'b0;
    wait_done("hold", d0, 200);
    check_row("hold", k0, 254, 4, d0);
    chk("hold_bubble_gap", rd_c[k0 + 2] - rd_c[k0 + 1], 3);

    // out-of-range shift sets sticky error and forces zero shifts
    k0 = nr; d0 = ndone;
    start_row(20, 1);
    wait_done("range", d0, 200);
    check_row("range", k0, 20, 1, d0);
    chk("range_fields", cap0[k0] + cap1[k0] + cap2[k0], 0);
    chk("range_err_sticky", err_range, 1);

    // empty row: done next cycle, no reads, error cleared by the accepted start
    k0 = nr; d0 = ndone;
    start_row(5, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_err_clr", err_range, 0);
    @(posedge clk); #1;
    chk("zero_done_pulse", done, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("zero_no_reads", nr - k0, 0);
    chk("zero_ndone", ndone - d0, 1);
    chk("zero_first_half", first_half, 1);

    // reset during CN issue
    k0 = nr; d0 = ndone;
    start_row(40, 6);
    t = 0;
    while (nr - k0 < 8 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mid_in_cn", first_half, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_rom_rd", rom_rd, 0);
    chk("mid_rom_addr", rom_addr, 0);
    chk("mid_first_half", first_half, 1);
    chk("mid_shifts", {shift0, shift1, shift2}, 0);
    chk("mid_valids", {sh_valid_in, sh_valid_out}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_no_done", ndone - d0, 0);

    k0 = nr; d0 = ndone;
    start_row(40, 2);
    wait_done("clean", d0, 200);
    check_row("clean", k0, 40, 2, d0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
